// File: rtl/mux_2to1_unstripe.sv
// Byte-unstriping 2:1 mux: two buffered byte lanes merged into one stream,
// read in strict lane0/lane1 alternation (inverse of the 1:2 striping demux).

module mux_2to1_unstripe_lane #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full,
    output logic              ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                count_q, count_d;
    logic                         ovf_q, ovf_d;
    logic                         push_ok;

    always_comb begin
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        push_ok  = push && ((count_q != CW'(DEPTH)) || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q | (push & ~push_ok);
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign ovf   = ovf_q;
endmodule

module mux_2to1_unstripe #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in_0,
    input  logic              valid_in_0,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic              valid_in_1,
    output logic [DATA_W-1:0] data_mux,
    output logic              valid_mux,
    output logic              lane_sel,
    output logic              full_0,
    output logic              full_1,
    output logic              ovf_0,
    output logic              ovf_1
);
    logic [1:0][DATA_W-1:0] din, head;
    logic [1:0]             vin, pop, empty, full, ovf;

    logic [DATA_W-1:0] data_mux_q, data_mux_d;
    logic              valid_mux_q, valid_mux_d;
    logic              lane_sel_q, lane_sel_d;

    assign din = {data_in_1, data_in_0};
    assign vin = {valid_in_1, valid_in_0};

    for (genvar g = 0; g < 2; g++) begin : g_lane
        mux_2to1_unstripe_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane (
            .clk_2f    (clk_2f),
            .reset     (reset),
            .push      (vin[g]),
            .push_data (din[g]),
            .pop       (pop[g]),
            .head      (head[g]),
            .empty     (empty[g]),
            .full      (full[g]),
            .ovf       (ovf[g])
        );
    end

    always_comb begin
        pop         = 2'b00;
        data_mux_d  = '0;
        valid_mux_d = 1'b0;
        lane_sel_d  = lane_sel_q;
        // Never skip an empty lane: that would reorder the striped bytes.
        if (!empty[lane_sel_q]) begin
            pop[lane_sel_q] = 1'b1;
            data_mux_d      = head[lane_sel_q];
            valid_mux_d     = 1'b1;
            lane_sel_d      = ~lane_sel_q;
        end
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            data_mux_q  <= '0;
            valid_mux_q <= 1'b0;
            lane_sel_q  <= 1'b0;
        end else begin
            data_mux_q  <= data_mux_d;
            valid_mux_q <= valid_mux_d;
            lane_sel_q  <= lane_sel_d;
        end
    end

    assign data_mux  = data_mux_q;
    assign valid_mux = valid_mux_q;
    assign lane_sel  = lane_sel_q;
    assign full_0    = full[0];
    assign full_1    = full[1];
    assign ovf_0     = ovf[0];
    assign ovf_1     = ovf[1];
endmodule
